alu4_op_sequencer: RTL and testbench



---
 rtl/alu4_pkg.sv | 31 +++
 rtl/alu_bit_slice.sv | 46 ++++
 rtl/alu4_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu4_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcode and state
// encodings, the default operand width and opcode classification helpers.
package alu4_pkg;

    localparam int unsigned ALU4_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // 110 and 111 are the only unassigned encodings.
    function automatic logic is_legal(input logic [2:0] op);
        return op[2:1] != 2'b11;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit AND/OR/XOR/full-adder cell; the single shared datapath resource
// stepped across the operand bits by the sequencer. Purely combinational.
module alu_bit_slice
    import alu4_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);

    logic b_eff;
    logic and_ab;
    logic or_ab;
    logic xor_ab;
    logic sum;

    // Subtraction adds the complement of B; the sequencer seeds carry-in with 1.
    assign b_eff  = (op == OP_SUB) ? ~b : b;
    assign and_ab = a & b_eff;
    assign or_ab  = a | b_eff;
    assign xor_ab = a ^ b_eff;
    assign sum    = xor_ab ^ cin;

    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_AND:  r = and_ab;
            OP_OR:   r = or_ab;
            OP_XOR:  r = xor_ab;
            OP_XNOR: r = ~xor_ab;
            OP_ADD, OP_SUB: begin
                r    = sum;
                cout = and_ab | (xor_ab & cin);
            end
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu4_op_sequencer.sv
// Round-robin arbiter plus bit-serial sequencer sharing one alu_bit_slice
// between two requesters. Define ALU4_OVF_FLAG_EN to add the overflow output.
module alu4_op_sequencer
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = ALU4_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             illegal
`ifdef ALU4_OVF_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sr_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic             owner_q;
    logic             ptr_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done_q;
    logic             done_id_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             zero_q;
    logic             illegal_q;
`ifdef ALU4_OVF_FLAG_EN
    logic             msb_cin_q;
    logic             overflow_q;
`endif

    logic       win_d;
    logic [2:0] win_op_d;
    logic       bit_d;
    logic       carry_d;

    // Operands shift right each step so the slice always sees bit 0.
    alu_bit_slice u_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .r    (bit_d),
        .cout (carry_d)
    );

    // ptr_q names the requester that wins a tie.
    always_comb begin
        win_d = ptr_q;
        if (req0 && !req1) begin
            win_d = 1'b0;
        end else if (req1 && !req0) begin
            win_d = 1'b1;
        end
        win_op_d = win_d ? op1 : op0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sr_q        <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU4_OVF_FLAG_EN
            msb_cin_q   <= 1'b0;
            overflow_q  <= 1'b0;
`endif
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        ptr_q   <= ~win_d;
                        owner_q <= win_d;
                        op_q    <= win_op_d;
                        a_q     <= win_d ? a1 : a0;
                        b_q     <= win_d ? b1 : b0;
                        idx_q   <= '0;
                        carry_q <= (win_op_d == OP_SUB);
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sr_q    <= {bit_d, sr_q[WIDTH-1:1]};
                    carry_q <= carry_d;
`ifdef ALU4_OVF_FLAG_EN
                    if (idx_q == LAST_IDX) begin
                        msb_cin_q <= carry_q;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q    <= 1'b1;
                    done_id_q <= owner_q;
                    if (is_legal(op_q)) begin
                        result_q    <= sr_q;
                        zero_q      <= (sr_q == '0);
                        carry_out_q <= is_arith(op_q) & carry_q;
                        illegal_q   <= 1'b0;
                    end else begin
                        result_q    <= '0;
                        zero_q      <= 1'b1;
                        carry_out_q <= 1'b0;
                        illegal_q   <= 1'b1;
                    end
`ifdef ALU4_OVF_FLAG_EN
                    overflow_q <= is_arith(op_q) & (msb_cin_q ^ carry_q);
`endif
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
`ifdef ALU4_OVF_FLAG_EN
    assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_alu4_op_sequencer.sv
// Bench for alu4_op_sequencer: directed vector table, multi-cycle corner
// sequences and random traffic against a cycle-count based reference model.
module tb_alu4_op_sequencer;

    localparam int W = 4;
    localparam int M = (1 << W) - 1;

    typedef struct {
        int res;
        bit c;
        bit z;
        bit ill;
        bit ov;
    } exp_t;

    typedef struct {
        bit         id;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e_res;
        bit         e_c;
        bit         e_z;
        bit         e_ill;
        bit         e_ov;
    } vec_t;

    logic         clk, rst, req0, req1;
    logic [2:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, done, done_id, carry_out, zero, illegal;
    logic [W-1:0] result;
`ifdef ALU4_OVF_FLAG_EN
    logic         overflow;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_acc = 0;
    int   acc_edge = -1;
    int   done_edge = 0;
    bit   last_gnt = 1'b1;
    bit   pend_v = 1'b0;
    bit   pend_id = 1'b0;
    bit   hold_id = 1'b0;
    bit   eg0, eg1, ed, eb;
    exp_t pend, hold;
    vec_t tab[9];

    alu4_op_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .carry_out(carry_out), .zero(zero), .illegal(illegal)
`ifdef ALU4_OVF_FLAG_EN
        , .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers, signed overflow from value range.
    function automatic exp_t model_op(input logic [2:0] op, input int a, input int b);
        exp_t e;
        int sa, sb, t;
        e.res = 0; e.c = 0; e.z = 0; e.ill = 0; e.ov = 0;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = a ^ b;
            3'd3: e.res = ~(a ^ b) & M;
            3'd4: begin
                e.res = (a + b) & M;
                e.c   = (a + b) > M;
                t     = sa + sb;
                e.ov  = (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
            end
            3'd5: begin
                e.res = (a - b) & M;
                e.c   = (a >= b);
                t     = sa - sb;
                e.ov  = (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Advance one clock; the model predicts from the inputs present at the edge.
    task automatic step();
        bit r0, r1, rs, w;
        logic [2:0] o0, o1;
        int xa0, xb0, xa1, xb1;
        r0 = req0; r1 = req1; rs = rst;
        o0 = op0; o1 = op1;
        xa0 = int'(a0); xb0 = int'(b0); xa1 = int'(a1); xb1 = int'(b1);
        @(posedge clk);
        #1;
        cyc++;
        eg0 = 0; eg1 = 0; ed = 0;
        if (rs) begin
            pend_v   = 0;
            acc_edge = -1;
            next_acc = cyc + 1;
            last_gnt = 1'b1;
            hold.res = 0; hold.c = 0; hold.z = 0; hold.ill = 0; hold.ov = 0;
            hold_id  = 0;
        end else begin
            if (cyc >= next_acc && (r0 || r1)) begin
                w        = (r0 && r1) ? !last_gnt : r1;
                last_gnt = w;
                eg0      = !w;
                eg1      = w;
                pend     = w ? model_op(o1, xa1, xb1) : model_op(o0, xa0, xb0);
                pend_id  = w;
                pend_v   = 1;
                acc_edge = cyc;
                done_edge = cyc + W + 1;
                next_acc = cyc + W + 2;
            end
            if (pend_v && cyc == done_edge) begin
                ed      = 1;
                hold    = pend;
                hold_id = pend_id;
                pend_v  = 0;
            end
        end
        eb = (acc_edge >= 0) && (cyc >= acc_edge) && (cyc <= acc_edge + W);
        check("ctl{gnt0,gnt1,done,busy}", {gnt0, gnt1, done, busy}, {eg0, eg1, ed, eb});
        check("out{id,res,c,z,ill}", {done_id, result, carry_out, zero, illegal},
              {hold_id, hold.res[W-1:0], hold.c, hold.z, hold.ill});
`ifdef ALU4_OVF_FLAG_EN
        check("overflow", overflow, hold.ov);
`endif
    endtask

    // sel 0: wait for any grant, sel 1: wait for done. Bounded.
    task automatic wait_sig(input bit sel, output int n, output bit to);
        n = 0;
        to = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (sel ? done : (gnt0 | gnt1)) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit to;
        if (v.id) begin
            req1 = 1; op1 = v.op; a1 = v.a; b1 = v.b;
        end else begin
            req0 = 1; op0 = v.op; a0 = v.a; b0 = v.b;
        end
        wait_sig(0, n, to);
        check("vec gnt timeout", to, 0);
        check("vec gnt id", {gnt1, gnt0}, v.id ? 2'b10 : 2'b01);
        req0 = 0; req1 = 0;
        wait_sig(1, n, to);
        check("vec done timeout", to, 0);
        check("vec latency", n, W + 1);
        check("vec done_id", done_id, v.id);
        check("vec result", result, v.e_res);
        check("vec carry_out", carry_out, v.e_c);
        check("vec zero", zero, v.e_z);
        check("vec illegal", illegal, v.e_ill);
`ifdef ALU4_OVF_FLAG_EN
        check("vec overflow", overflow, v.e_ov);
`endif
    endtask

    initial begin
        int n, bad;
        bit to;
        //            id  op      a        b        res      c  z  ill ov
        tab[0] = '{1'b0, 3'b100, 4'b0111, 4'b0001, 4'b1000, 0, 0, 0, 1};
        tab[1] = '{1'b1, 3'b101, 4'b0011, 4'b0101, 4'b1110, 0, 0, 0, 0};
        tab[2] = '{1'b0, 3'b111, 4'b1011, 4'b0110, 4'b0000, 0, 1, 1, 0};
        tab[3] = '{1'b1, 3'b000, 4'b1100, 4'b1010, 4'b1000, 0, 0, 0, 0};
        tab[4] = '{1'b0, 3'b001, 4'b0101, 4'b0010, 4'b0111, 0, 0, 0, 0};
        tab[5] = '{1'b1, 3'b011, 4'b1010, 4'b1010, 4'b1111, 0, 0, 0, 0};
        tab[6] = '{1'b0, 3'b101, 4'b0101, 4'b0101, 4'b0000, 1, 1, 0, 0};
        tab[7] = '{1'b1, 3'b100, 4'b1111, 4'b0001, 4'b0000, 1, 1, 0, 0};
        tab[8] = '{1'b0, 3'b110, 4'b1111, 4'b1111, 4'b0000, 0, 1, 1, 0};

        rst = 1; req0 = 0; req1 = 0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step();
        step();
        rst = 0;
        check("reset state", {busy, done, gnt0, gnt1, done_id, result, carry_out, zero, illegal}, '0);

        for (int i = 0; i < 9; i++) run_vec(tab[i]);

        // Tie straight after reset: requester 0 first, then 1 at the next IDLE.
        rst = 1;
        step();
        rst = 0;
        req0 = 1; op0 = 3'b010; a0 = 4'b1010; b0 = 4'b0110;
        req1 = 1; op1 = 3'b010; a1 = 4'b1111; b1 = 4'b1111;
        wait_sig(0, n, to);
        check("tie first grant", {to, gnt1, gnt0}, 3'b001);
        req0 = 0;
        wait_sig(1, n, to);
        check("tie first result", {to, done_id, result, zero}, {1'b0, 1'b0, 4'b1100, 1'b0});
        wait_sig(0, n, to);
        check("tie second grant", {to, gnt1, gnt0}, 3'b010);
        req1 = 0;
        wait_sig(1, n, to);
        check("tie second result", {to, done_id, result, zero}, {1'b0, 1'b1, 4'b0000, 1'b1});

        // Continuous contention must alternate 0,1,0,1.
        req0 = 1; req1 = 1;
        for (int k = 0; k < 4; k++) begin
            wait_sig(0, n, to);
            check("alternation", {to, gnt1, gnt0}, (k % 2) ? 3'b010 : 3'b001);
        end
        req0 = 0; req1 = 0;
        wait_sig(1, n, to);

        // Reset on the second EXEC edge aborts the operation.
        req0 = 1; op0 = 3'b100; a0 = 4'b0111; b0 = 4'b0001;
        wait_sig(0, n, to);
        check("abort grant", {to, gnt0}, 2'b01);
        req0 = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        check("abort busy", busy, 0);
        check("abort result", result, 0);
        bad = 0;
        for (int i = 0; i < W + 3; i++) begin
            step();
            if (done) bad++;
        end
        check("abort no done", bad, 0);
        run_vec(tab[0]);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (!req0 && $urandom_range(2, 0) == 0) begin
                req0 = 1; op0 = 3'($urandom_range(7, 0));
                a0 = W'($urandom); b0 = W'($urandom);
            end
            if (!req1 && $urandom_range(2, 0) == 0) begin
                req1 = 1; op1 = 3'($urandom_range(7, 0));
                a1 = W'($urandom); b1 = W'($urandom);
            end
            step();
            if (eg0) req0 = 0;
            if (eg1) req1 = 0;
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 2 * W + 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
